ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: RAM data width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 8: RAM entry count; AW = $clog2(DEPTH).
REQ-003 The module SHALL have port clk, input, 1: clock; all state SHALL update on the rising edge.
REQ-004 The module SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The module SHALL have port req_valid_i, input, 2: per-requester request valid.
REQ-006 The module SHALL have port req_we_i, input, 2: per-requester write (1) or read (0).
REQ-007 The module SHALL have port req_lock_i, input, 2: per-requester hold-grant-after-this-access.
REQ-008 The module SHALL have port req_addr_i, input, 2xAW: per-requester address.
REQ-009 The module SHALL have port req_wdata_i, input, 2xWIDTH: per-requester write data.
REQ-010 The module SHALL have port req_ready_o, output, 2: per-requester grant/accept.
REQ-011 The module SHALL have port resp_valid_o, output, 2: per-requester read-data valid.
REQ-012 The module SHALL have port resp_rdata_o, output, WIDTH: read data, shared by both requesters.
REQ-013 The module SHALL have port ram_we_o, output, 1: RAM write enable.
REQ-014 The module SHALL have port ram_a_o, output, AW: RAM address.
REQ-015 The module SHALL have port ram_d_o, output, WIDTH: RAM write data.
REQ-016 The module SHALL have port ram_q_i, input, WIDTH: RAM read data, valid the cycle after the address is presented.

Function
REQ-017 The module SHALL grant at most one requester per cycle; a request is accepted when req_valid_i[i] && req_ready_o[i].
REQ-018 req_ready_o[i] SHALL be combinational; it SHALL be 1 only when requester i is granted, never when req_valid_i[i]=0.
REQ-019 In state ARB with both valid, the requester indicated by 1-bit pointer rr SHALL win; with one valid, that one SHALL win.
REQ-020 After any accepted request from i, rr SHALL become the other requester.
REQ-021 When a request is granted, ram_we_o, ram_a_o and ram_d_o SHALL be driven combinationally from it; otherwise all three SHALL be 0.
REQ-022 The FSM SHALL have states ARB and LOCKED, with a 1-bit owner register.
REQ-023 Accepted request with req_lock_i=1 in ARB: next state SHALL be LOCKED, owner=i.
REQ-024 In LOCKED only the owner SHALL be grantable; the other requester's ready SHALL be 0 even when the owner is idle.
REQ-025 In LOCKED, an accepted owner request with req_lock_i=0 SHALL return the FSM to ARB; lock=1 SHALL stay LOCKED; an idle owner SHALL leave the state unchanged.
REQ-026 For an accepted read in cycle t, resp_valid_o[i] SHALL be 1 in cycle t+1 only, with resp_rdata_o = ram_q_i; writes SHALL produce no response.
REQ-027 resp_rdata_o SHALL be 0 when no resp_valid_o bit is set; at most one resp_valid_o bit SHALL be set per cycle.
REQ-028 A read accepted the cycle after a write to the same address SHALL return the newly written data; no stall or forwarding is added.
REQ-029 Back-to-back accepted requests SHALL sustain one access per cycle with no bubbles.

Reset
REQ-030 While rst=1: state=ARB, rr=0, owner=0, pending response cleared; req_ready_o=0, resp_valid_o=0, resp_rdata_o=0, ram_we_o=0, ram_a_o=0, ram_d_o=0.
REQ-031 A read accepted in the cycle rst rises SHALL produce no response; an active lock SHALL be released.
REQ-032 In the first cycle after rst falls, resp_valid_o SHALL be 0 and requester 0 SHALL have priority.

Verification
REQ-033 Bench SHALL cover: write r0 addr 3 data 0xA5, then read r0 addr 3 next cycle -> resp_valid_o=2'b01 one cycle after the read, resp_rdata_o=0xA5.
REQ-034 Bench SHALL cover: both requesters hold valid reads for 4 cycles after reset -> grants r0,r1,r0,r1; resp_valid_o alternates 01,10,01,10.
REQ-035 Bench SHALL cover: r1 read with lock=1, then r1 write lock=1, then r1 idle 2 cycles, then r1 read lock=0, with r0 valid throughout -> req_ready_o[0]=0 until the lock=0 access is accepted, then r0 granted next cycle.
REQ-036 Bench SHALL cover: r0 read accepted in the same cycle rst=1 -> resp_valid_o=0 in the next cycle; after reset a read of any address returns 0.
REQ-037 Bench SHALL cover: no valid requests -> ram_we_o=0, ram_a_o=0, ram_d_o=0, resp_valid_o=0 every cycle.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Round-robin between requesters, with an optional lock that keeps the grant with one owner.
module ram_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid_i,
    input  logic [1:0]           req_we_i,
    input  logic [1:0]           req_lock_i,
    input  logic [2*AW-1:0]      req_addr_i,
    input  logic [2*WIDTH-1:0]   req_wdata_i,
    output logic [1:0]           req_ready_o,
    output logic [1:0]           resp_valid_o,
    output logic [WIDTH-1:0]     resp_rdata_o,
    output logic                 ram_we_o,
    output logic [AW-1:0]        ram_a_o,
    output logic [WIDTH-1:0]     ram_d_o,
    input  logic [WIDTH-1:0]     ram_q_i
);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic       owner_q, owner_d;
    logic [1:0] resp_pend_q, resp_pend_d;

    logic       gnt_valid;
    logic       gnt_idx;
    logic       gnt_lock;

    // Grant selection; while locked, only the owner may be granted.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (!rst) begin
            if (state_q == LOCKED) begin
                gnt_valid = req_valid_i[owner_q];
                gnt_idx   = owner_q;
            end else if (&req_valid_i) begin
                gnt_valid = 1'b1;
                gnt_idx   = rr_q;
            end else if (req_valid_i[0]) begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b0;
            end else if (req_valid_i[1]) begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b1;
            end
        end
    end

    assign gnt_lock       = req_lock_i[gnt_idx];
    assign req_ready_o[0] = gnt_valid & ~gnt_idx;
    assign req_ready_o[1] = gnt_valid & gnt_idx;

    always_comb begin
        ram_we_o = 1'b0;
        ram_a_o  = '0;
        ram_d_o  = '0;
        if (gnt_valid) begin
            ram_we_o = req_we_i[gnt_idx];
            ram_a_o  = gnt_idx ? req_addr_i[2*AW-1:AW] : req_addr_i[AW-1:0];
            ram_d_o  = gnt_idx ? req_wdata_i[2*WIDTH-1:WIDTH] : req_wdata_i[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        resp_pend_d = 2'b00;
        if (gnt_valid) begin
            rr_d = ~gnt_idx;
            if (!req_we_i[gnt_idx]) begin
                resp_pend_d[gnt_idx] = 1'b1;
            end
            if (state_q == ARB && gnt_lock) begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end else if (state_q == LOCKED && !gnt_lock) begin
                state_d = ARB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            resp_pend_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            resp_pend_q <= resp_pend_d;
        end
    end

    // Responses are masked during reset so a stale pending read never leaks out.
    assign resp_valid_o = rst ? 2'b00 : resp_pend_q;
    assign resp_rdata_o = (|resp_valid_o) ? ram_q_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model and a behavioural RAM.
module tb_ram_port_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic               clk;
    logic               rst;
    logic [1:0]         req_valid_i;
    logic [1:0]         req_we_i;
    logic [1:0]         req_lock_i;
    logic [2*AW-1:0]    req_addr_i;
    logic [2*WIDTH-1:0] req_wdata_i;
    logic [1:0]         req_ready_o;
    logic [1:0]         resp_valid_o;
    logic [WIDTH-1:0]   resp_rdata_o;
    logic               ram_we_o;
    logic [AW-1:0]      ram_a_o;
    logic [WIDTH-1:0]   ram_d_o;
    logic [WIDTH-1:0]   ram_q_i;

    int n_checks = 0;
    int n_fail   = 0;

    ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_lock_i(req_lock_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .ram_we_o(ram_we_o), .ram_a_o(ram_a_o), .ram_d_o(ram_d_o), .ram_q_i(ram_q_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous RAM, cleared by reset so post-reset reads return 0.
    logic [WIDTH-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
            ram_q_i <= '0;
        end else begin
            ram_q_i <= ram_mem[ram_a_o];
            if (ram_we_o) ram_mem[ram_a_o] <= ram_d_o;
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        req_valid_i = v;
        req_we_i    = we;
        req_lock_i  = lk;
        req_addr_i  = {a1, a0};
        req_wdata_i = {d1, d0};
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b11, 2'b11, 2'b11, 3, 5, 8'h12, 8'h34);
        settle();
        n_checks++;
        if (req_ready_o !== 2'b00) begin
            n_fail++; $display("[TB] FAIL reset_ready: got %b want 00", req_ready_o);
        end
        n_checks++;
        if ({ram_we_o, ram_a_o, ram_d_o} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_ram: got we=%b a=%0d d=%h want 0", ram_we_o, ram_a_o, ram_d_o);
        end
        n_checks++;
        if ({resp_valid_o, resp_rdata_o} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_resp: got v=%b d=%h want 0", resp_valid_o, resp_rdata_o);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_idle();
        drive(2'b00, 2'b11, 2'b11, 5, 6, 8'hFF, 8'hEE);
        for (int c = 0; c < 4; c++) begin
            settle();
            n_checks++;
            if ({ram_we_o, ram_a_o, ram_d_o, resp_valid_o} !== '0) begin
                n_fail++;
                $display("[TB] FAIL idle_outputs: cycle %0d got we=%b a=%0d d=%h rv=%b want all 0",
                         c, ram_we_o, ram_a_o, ram_d_o, resp_valid_o);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        drive(2'b01, 2'b01, 2'b00, 3, 0, 8'hA5, 8'h00);
        settle();
        n_checks++;
        if ({req_ready_o, ram_we_o, ram_a_o, ram_d_o} !== {2'b01, 1'b1, 3'd3, 8'hA5}) begin
            n_fail++;
            $display("[TB] FAIL wr_issue: got rdy=%b we=%b a=%0d d=%h want 01 1 3 a5",
                     req_ready_o, ram_we_o, ram_a_o, ram_d_o);
        end
        tick();
        drive(2'b01, 2'b00, 2'b00, 3, 0, 8'h00, 8'h00);
        settle();
        n_checks++;
        if ({req_ready_o, ram_we_o, ram_a_o, resp_valid_o} !== {2'b01, 1'b0, 3'd3, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL rd_issue: got rdy=%b we=%b a=%0d rv=%b want 01 0 3 00",
                     req_ready_o, ram_we_o, ram_a_o, resp_valid_o);
        end
        tick();
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        settle();
        n_checks++;
        if ({resp_valid_o, resp_rdata_o} !== {2'b01, 8'hA5}) begin
            n_fail++; $display("[TB] FAIL rd_resp: got v=%b d=%h want 01 a5", resp_valid_o, resp_rdata_o);
        end
        tick();
        settle();
        n_checks++;
        if (resp_valid_o !== 2'b00) begin
            n_fail++; $display("[TB] FAIL rd_resp_once: got %b want 00", resp_valid_o);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt [4];
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        drive(2'b11, 2'b00, 2'b00, 1, 2, 0, 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
            settle();
            if (c < 4) begin
                n_checks++;
                if (req_ready_o !== exp_gnt[c]) begin
                    n_fail++; $display("[TB] FAIL rr_grant: cycle %0d got %b want %b", c, req_ready_o, exp_gnt[c]);
                end
            end
            n_checks++;
            if (resp_valid_o !== ((c == 0) ? 2'b00 : exp_gnt[c-1])) begin
                n_fail++;
                $display("[TB] FAIL rr_resp: cycle %0d got %b want %b", c, resp_valid_o,
                         (c == 0) ? 2'b00 : exp_gnt[c-1]);
            end
            tick();
        end
    endtask

    task automatic test_lock();
        logic [1:0] v1_tab  [6];
        logic [1:0] we1_tab [6];
        logic [1:0] lk1_tab [6];
        logic [1:0] exp_rdy [6];
        v1_tab  = '{1, 1, 0, 0, 1, 0};
        we1_tab = '{0, 1, 0, 0, 0, 0};
        lk1_tab = '{1, 1, 0, 0, 0, 0};
        exp_rdy = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01};
        do_reset();
        // A lone r0 access hands round-robin priority to r1 before the lock sequence.
        drive(2'b01, 2'b01, 2'b00, 0, 0, 8'h11, 0);
        settle();
        n_checks++;
        if (req_ready_o !== 2'b01) begin
            n_fail++; $display("[TB] FAIL lock_pre: got %b want 01", req_ready_o);
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            drive({v1_tab[c][0], 1'b1}, {we1_tab[c][0], 1'b0}, {lk1_tab[c][0], 1'b0}, 0, 4, 0, 8'h5A);
            settle();
            n_checks++;
            if (req_ready_o !== exp_rdy[c]) begin
                n_fail++; $display("[TB] FAIL lock_ready: step %0d got %b want %b", c, req_ready_o, exp_rdy[c]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(2'b10, 2'b00, 2'b10, 0, 2, 0, 0);
        settle();
        n_checks++;
        if (req_ready_o !== 2'b10) begin
            n_fail++; $display("[TB] FAIL rstmid_lock: got %b want 10", req_ready_o);
        end
        tick();
        rst = 1'b1;
        drive(2'b01, 2'b00, 2'b00, 6, 0, 0, 0);
        settle();
        n_checks++;
        if ({req_ready_o, resp_valid_o} !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL rstmid_inrst: got rdy=%b rv=%b want 00 00", req_ready_o, resp_valid_o);
        end
        tick();
        rst = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 6, 1, 0, 0);
        settle();
        n_checks++;
        if ({req_ready_o, resp_valid_o} !== {2'b01, 2'b00}) begin
            n_fail++; $display("[TB] FAIL rstmid_after: got rdy=%b rv=%b want 01 00", req_ready_o, resp_valid_o);
        end
        tick();
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        settle();
        n_checks++;
        if ({resp_valid_o, resp_rdata_o} !== {2'b01, 8'h00}) begin
            n_fail++; $display("[TB] FAIL rstmid_zero: got v=%b d=%h want 01 00", resp_valid_o, resp_rdata_o);
        end
        tick();
    endtask

    task automatic test_random();
        bit               m_locked;
        int               m_owner, m_rr, m_resp_who, winner;
        logic [WIDTH-1:0] m_resp_data;
        logic [WIDTH-1:0] m_mem [DEPTH];
        logic [1:0]       v, we, lk, exp_rdy, exp_rv;
        logic [AW-1:0]    a [2];
        logic [WIDTH-1:0] d [2];
        logic             exp_we;
        logic [AW-1:0]    exp_a;
        logic [WIDTH-1:0] exp_d, exp_rd;
        do_reset();
        m_locked = 0; m_owner = 0; m_rr = 0; m_resp_who = -1; m_resp_data = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            v     = 2'($urandom_range(0, 3));
            we    = 2'($urandom_range(0, 3));
            lk    = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            a[0]  = AW'($urandom_range(0, DEPTH - 1));
            a[1]  = AW'($urandom_range(0, DEPTH - 1));
            d[0]  = WIDTH'($urandom);
            d[1]  = WIDTH'($urandom);
            drive(v, we, lk, a[0], a[1], d[0], d[1]);
            winner = -1;
            if (!rst) begin
                if (m_locked) winner = v[m_owner] ? m_owner : -1;
                else if (v == 2'b11) winner = m_rr;
                else if (v == 2'b01) winner = 0;
                else if (v == 2'b10) winner = 1;
            end
            exp_rdy = (winner < 0) ? 2'b00 : 2'(1 << winner);
            exp_we  = (winner < 0) ? 1'b0 : we[winner];
            exp_a   = (winner < 0) ? '0 : a[winner];
            exp_d   = (winner < 0) ? '0 : d[winner];
            exp_rv  = (rst || m_resp_who < 0) ? 2'b00 : 2'(1 << m_resp_who);
            exp_rd  = (exp_rv == 2'b00) ? '0 : m_resp_data;
            settle();
            n_checks++;
            if (req_ready_o !== exp_rdy) begin
                n_fail++; $display("[TB] FAIL rnd_ready: cycle %0d got %b want %b", c, req_ready_o, exp_rdy);
            end
            n_checks++;
            if ({ram_we_o, ram_a_o, ram_d_o} !== {exp_we, exp_a, exp_d}) begin
                n_fail++;
                $display("[TB] FAIL rnd_ram: cycle %0d got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                         c, ram_we_o, ram_a_o, ram_d_o, exp_we, exp_a, exp_d);
            end
            n_checks++;
            if ({resp_valid_o, resp_rdata_o} !== {exp_rv, exp_rd}) begin
                n_fail++;
                $display("[TB] FAIL rnd_resp: cycle %0d got v=%b d=%h want v=%b d=%h",
                         c, resp_valid_o, resp_rdata_o, exp_rv, exp_rd);
            end
            // Advance the transaction-level model by one access.
            if (rst) begin
                m_locked = 0; m_owner = 0; m_rr = 0; m_resp_who = -1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end else begin
                m_resp_who = -1;
                if (winner >= 0) begin
                    if (we[winner]) m_mem[a[winner]] = d[winner];
                    else begin
                        m_resp_who  = winner;
                        m_resp_data = m_mem[a[winner]];
                    end
                    m_rr = 1 - winner;
                    if (!m_locked && lk[winner]) begin
                        m_locked = 1; m_owner = winner;
                    end else if (m_locked && !lk[winner]) begin
                        m_locked = 0;
                    end
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        test_reset();
        test_idle();
        test_write_read();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
